// File: rtl/emotion_phrase_generator.sv
// Turns a latched emotion result into an 8- or 16-note phrase. Each emotion has its own scale and tempo.
// An LFSR picks the octave and the scale-degree step for every note.
module emotion_phrase_generator #(
  parameter int         TEMPO_BASE = 16,
  parameter int         ROOT_NOTE  = 24,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] emotion_code,
  input  logic [7:0] emotion_confidence,
  input  logic       emotion_valid,
  input  logic       enable,
  output logic [5:0] note_played,
  output logic       load_new_note,
  output logic [4:0] note_index,
  output logic       busy,
  output logic       phrase_done
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

  // Scale tables packed as nibbles, degree 0 in the low nibble.
  localparam logic [31:0] MAJOR      = 32'h0B975420;
  localparam logic [31:0] MINOR      = 32'h0A875320;
  localparam logic [31:0] PENTATONIC = 32'h00097420;
  localparam logic [31:0] DIMINISHED = 32'hA9764310;

  state_t      state;
  logic [1:0]  code;
  logic        len_long;
  logic [7:0]  lfsr;
  logic [2:0]  degree;
  logic [15:0] cnt;
  logic [7:0]  seed;
  logic [4:0]  index_next;
  logic        last;

  function automatic logic [15:0] period(input logic [1:0] c);
    logic [1:0] shift;
    case (c)
      2'd0:    shift = 2'd1;
      2'd1:    shift = 2'd3;
      2'd2:    shift = 2'd2;
      default: shift = 2'd0;
    endcase
    return 16'(TEMPO_BASE) << shift;
  endfunction

  function automatic logic [3:0] scale_len(input logic [1:0] c);
    case (c)
      2'd0, 2'd1: return 4'd7;
      2'd2:       return 4'd5;
      default:    return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] scale_tone(input logic [1:0] c, input logic [2:0] d);
    logic [31:0] tbl;
    case (c)
      2'd0:    tbl = MAJOR;
      2'd1:    tbl = MINOR;
      2'd2:    tbl = PENTATONIC;
      default: tbl = DIMINISHED;
    endcase
    return tbl[{d, 2'b00} +: 4];
  endfunction

  // degree < len and step <= 3, so the sum is below 2*len and one subtract wraps it.
  function automatic logic [2:0] next_degree(input logic [1:0] c, input logic [2:0] d,
                                             input logic [1:0] step);
    logic [3:0] sum;
    logic [3:0] len;
    sum = {1'b0, d} + {2'b00, step};
    len = scale_len(c);
    if (sum >= len) sum = sum - len;
    return sum[2:0];
  endfunction

  assign seed       = LFSR_SEED ^ emotion_confidence;
  assign index_next = note_index + 5'd1;
  assign last       = (index_next == (len_long ? 5'd16 : 5'd8));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      code          <= 2'd0;
      len_long      <= 1'b0;
      lfsr          <= LFSR_SEED;
      degree        <= 3'd0;
      cnt           <= 16'd0;
      note_played   <= 6'd0;
      load_new_note <= 1'b0;
      note_index    <= 5'd0;
      busy          <= 1'b0;
      phrase_done   <= 1'b0;
    end else begin
      load_new_note <= 1'b0;
      phrase_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (emotion_valid) begin
            state      <= LOAD;
            busy       <= 1'b1;
            code       <= emotion_code;
            len_long   <= emotion_confidence[7];
            lfsr       <= (seed == 8'h00) ? 8'h01 : seed;
            degree     <= 3'd0;
            note_index <= 5'd0;
          end else begin
            busy <= 1'b0;
          end
        end
        LOAD: begin
          cnt   <= period(code) - 16'd1;
          state <= WAIT;
        end
        WAIT: begin
          if (enable) begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else begin
              note_played   <= 6'(ROOT_NOTE) + (lfsr[2] ? 6'd12 : 6'd0)
                               + {2'b00, scale_tone(code, degree)};
              load_new_note <= 1'b1;
              note_index    <= index_next;
              cnt           <= period(code) - 16'd1;
              degree        <= next_degree(code, degree, lfsr[1:0]);
              lfsr          <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
              if (last) state <= DONE;
            end
          end
        end
        DONE: begin
          // busy stays up through the phrase_done cycle and drops on the next IDLE edge.
          phrase_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emotion_phrase_generator.sv
// Directed bench for emotion_phrase_generator: two instances (TEMPO_BASE 4 and 2) share all inputs.
module tb_emotion_phrase_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] emotion_code;
  logic [7:0] emotion_confidence;
  logic       emotion_valid;
  logic       enable;

  logic [5:0] note_a, note_b;
  logic       lnn_a, lnn_b, busy_a, busy_b, done_a, done_b;
  logic [4:0] idx_a, idx_b;

  emotion_phrase_generator #(.TEMPO_BASE(4), .ROOT_NOTE(24), .LFSR_SEED(8'hA5)) dut_a (
    .clk(clk), .reset(reset), .emotion_code(emotion_code),
    .emotion_confidence(emotion_confidence), .emotion_valid(emotion_valid), .enable(enable),
    .note_played(note_a), .load_new_note(lnn_a), .note_index(idx_a), .busy(busy_a),
    .phrase_done(done_a));

  emotion_phrase_generator #(.TEMPO_BASE(2), .ROOT_NOTE(24), .LFSR_SEED(8'hA5)) dut_b (
    .clk(clk), .reset(reset), .emotion_code(emotion_code),
    .emotion_confidence(emotion_confidence), .emotion_valid(emotion_valid), .enable(enable),
    .note_played(note_b), .load_new_note(lnn_b), .note_index(idx_b), .busy(busy_b),
    .phrase_done(done_b));

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  logic       m_lnn, m_busy, m_done;
  logic [5:0] m_note;
  always_comb begin
    m_lnn  = lnn_a;  m_busy = busy_a; m_done = done_a; m_note = note_a;
    if (sel == 1) begin
      m_lnn = lnn_b; m_busy = busy_b; m_done = done_b; m_note = note_b;
    end
  end

  int         st_t[32];
  logic [5:0] st_note[32];
  logic [5:0] saved[3];
  int         n_st, done_t, busy_at0, busy_after, timeout;
  logic [5:0] exp_note[32];

  int tbl[4][8] = '{'{0,2,4,5,7,9,11,0}, '{0,2,3,5,7,8,10,0},
                    '{0,2,4,7,9,0,0,0},  '{0,1,3,4,6,7,9,10}};
  int slen[4] = '{7,7,5,8};

  // Reference note sequence for a given trigger.
  task automatic build_model(input int code, input int conf);
    logic [7:0] l;
    int d;
    l = 8'hA5 ^ conf[7:0];
    if (l == 8'h00) l = 8'h01;
    d = 0;
    for (int i = 0; i < 32; i++) begin
      exp_note[i] = 6'(24 + (l[2] ? 12 : 0) + tbl[code][d]);
      d = (d + int'(l[1:0])) % slen[code];
      l = {l[6:0], ^(l & 8'hB8)};
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_a !== 1'b0 || busy_b !== 1'b0) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 2000) timeout = 1;
  endtask

  // Runs one phrase, recording strobe edges (relative to the trigger edge) and notes.
  task automatic capture(input int do_trig, input int code, input int conf, input int stop_t,
                         input int dis_t, input int v1_on, input int v1_off,
                         input int v2_on, input int v2_off);
    int t;
    timeout = 0; n_st = 0; done_t = -1; busy_after = -1;
    if (do_trig != 0) begin
      wait_idle();
      emotion_code = code[1:0];
      emotion_confidence = conf[7:0];
      emotion_valid = 1'b1;
      @(posedge clk); #1;
      emotion_valid = 1'b0;
    end
    t = 0;
    busy_at0 = int'(m_busy);
    while (timeout == 0) begin
      @(posedge clk); #1; t++;
      if (m_lnn === 1'b1 && n_st < 32) begin st_t[n_st] = t; st_note[n_st] = m_note; n_st++; end
      if (m_done === 1'b1 && done_t < 0) done_t = t;
      if (t == dis_t) enable = 1'b0;
      if (t == dis_t + 5) enable = 1'b1;
      if (t == v1_on || t == v2_on) begin
        emotion_valid = 1'b1; emotion_code = 2'd3; emotion_confidence = 8'hFF;
      end
      if (t == v1_off || t == v2_off) emotion_valid = 1'b0;
      if (t == stop_t) break;
      if (done_t >= 0 && t == done_t + 1) begin busy_after = int'(m_busy); break; end
      if (t >= 3000) timeout = 1;
    end
    emotion_valid = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; emotion_valid = 1'b0; emotion_code = 2'd0;
    emotion_confidence = 8'd0;
    #2 reset = 1'b0;
    #1;
    n_checks++; if (note_a !== 6'd0) begin n_fail++; $display("FAIL reset_note got %0d exp 0", note_a); end
    n_checks++; if (lnn_a !== 1'b0) begin n_fail++; $display("FAIL reset_strobe got %b exp 0", lnn_a); end
    n_checks++; if (idx_a !== 5'd0) begin n_fail++; $display("FAIL reset_index got %0d exp 0", idx_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done_a); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_happy();
    sel = 0;
    capture(1, 0, 0, -1, -1, -1, -1, -1, -1);
    build_model(0, 0);
    n_checks++; if (timeout != 0) begin n_fail++; $display("FAIL happy_timeout got %0d exp 0", timeout); end
    n_checks++; if (busy_at0 != 1) begin n_fail++; $display("FAIL happy_busy_k got %0d exp 1", busy_at0); end
    n_checks++; if (n_st != 8) begin n_fail++; $display("FAIL happy_count got %0d exp 8", n_st); end
    n_checks++; if (st_t[0] != 9) begin n_fail++; $display("FAIL happy_t0 got %0d exp 9", st_t[0]); end
    n_checks++; if (st_note[0] !== 6'd36) begin n_fail++; $display("FAIL happy_n0 got %0d exp 36", st_note[0]); end
    n_checks++; if (st_t[1] != 17) begin n_fail++; $display("FAIL happy_t1 got %0d exp 17", st_t[1]); end
    n_checks++; if (st_note[1] !== 6'd26) begin n_fail++; $display("FAIL happy_n1 got %0d exp 26", st_note[1]); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (st_note[i] !== exp_note[i]) begin n_fail++; $display("FAIL happy_note%0d got %0d exp %0d", i, st_note[i], exp_note[i]); end
    end
    for (int i = 1; i < 8; i++) begin
      n_checks++;
      if (st_t[i] - st_t[i-1] != 8) begin n_fail++; $display("FAIL happy_gap%0d got %0d exp 8", i, st_t[i] - st_t[i-1]); end
    end
    n_checks++; if (done_t != st_t[7] + 1) begin n_fail++; $display("FAIL happy_done_t got %0d exp %0d", done_t, st_t[7] + 1); end
    n_checks++; if (busy_after != 0) begin n_fail++; $display("FAIL happy_busy_fall got %0d exp 0", busy_after); end
    n_checks++; if (note_a !== st_note[7]) begin n_fail++; $display("FAIL happy_hold got %0d exp %0d", note_a, st_note[7]); end
    n_checks++; if (idx_a !== 5'd8) begin n_fail++; $display("FAIL happy_index got %0d exp 8", idx_a); end
  endtask

  task automatic test_angry();
    int bad;
    sel = 0;
    capture(1, 3, 8'h80, -1, -1, -1, -1, -1, -1);
    build_model(3, 8'h80);
    n_checks++; if (n_st != 16) begin n_fail++; $display("FAIL angry_count got %0d exp 16", n_st); end
    n_checks++; if (st_t[0] != 5) begin n_fail++; $display("FAIL angry_t0 got %0d exp 5", st_t[0]); end
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (st_note[i] < 6'd24 || st_note[i] > 6'd47) bad++;
      n_checks++;
      if (st_note[i] !== exp_note[i]) begin n_fail++; $display("FAIL angry_note%0d got %0d exp %0d", i, st_note[i], exp_note[i]); end
      if (i > 0) begin
        n_checks++;
        if (st_t[i] - st_t[i-1] != 4) begin n_fail++; $display("FAIL angry_gap%0d got %0d exp 4", i, st_t[i] - st_t[i-1]); end
      end
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL angry_range got %0d out-of-range exp 0", bad); end
    n_checks++; if (idx_a !== 5'd16) begin n_fail++; $display("FAIL angry_index got %0d exp 16", idx_a); end
    n_checks++; if (busy_after != 0) begin n_fail++; $display("FAIL angry_busy_fall got %0d exp 0", busy_after); end
  endtask

  task automatic test_sad_enable();
    int hits;
    sel = 1;
    capture(1, 1, 8'h10, -1, 20, -1, -1, -1, -1);
    build_model(1, 8'h10);
    n_checks++; if (n_st != 8) begin n_fail++; $display("FAIL sad_count got %0d exp 8", n_st); end
    n_checks++; if (st_t[0] != 17) begin n_fail++; $display("FAIL sad_t0 got %0d exp 17", st_t[0]); end
    n_checks++; if (st_t[1] - st_t[0] != 21) begin n_fail++; $display("FAIL sad_stretch got %0d exp 21", st_t[1] - st_t[0]); end
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      if (st_t[i] >= 21 && st_t[i] <= 25) hits++;
      n_checks++;
      if (st_note[i] !== exp_note[i]) begin n_fail++; $display("FAIL sad_note%0d got %0d exp %0d", i, st_note[i], exp_note[i]); end
      if (i >= 2) begin
        n_checks++;
        if (st_t[i] - st_t[i-1] != 16) begin n_fail++; $display("FAIL sad_gap%0d got %0d exp 16", i, st_t[i] - st_t[i-1]); end
      end
    end
    n_checks++; if (hits != 0) begin n_fail++; $display("FAIL sad_disabled_strobe got %0d exp 0", hits); end
    n_checks++; if (idx_b !== 5'd8) begin n_fail++; $display("FAIL sad_index got %0d exp 8", idx_b); end
    sel = 0;
  endtask

  task automatic test_busy_trigger();
    sel = 0;
    capture(1, 2, 8'h33, -1, -1, 30, 31, 129, 131);
    build_model(2, 8'h33);
    n_checks++; if (n_st != 8) begin n_fail++; $display("FAIL busy_count got %0d exp 8", n_st); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (st_note[i] !== exp_note[i]) begin n_fail++; $display("FAIL busy_note%0d got %0d exp %0d", i, st_note[i], exp_note[i]); end
    end
    n_checks++; if (st_t[7] != 129) begin n_fail++; $display("FAIL busy_last_t got %0d exp 129", st_t[7]); end
    n_checks++; if (done_t != 130) begin n_fail++; $display("FAIL busy_done_t got %0d exp 130", done_t); end
    n_checks++; if (busy_after != 1) begin n_fail++; $display("FAIL busy_retrigger got %0d exp 1", busy_after); end
    capture(0, 3, 8'hFF, -1, -1, -1, -1, -1, -1);
    build_model(3, 8'hFF);
    n_checks++; if (n_st != 16) begin n_fail++; $display("FAIL retrig_count got %0d exp 16", n_st); end
    n_checks++; if (st_t[0] != 5) begin n_fail++; $display("FAIL retrig_t0 got %0d exp 5", st_t[0]); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (st_note[i] !== exp_note[i]) begin n_fail++; $display("FAIL retrig_note%0d got %0d exp %0d", i, st_note[i], exp_note[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int strobes;
    sel = 0;
    capture(1, 0, 0, 25, -1, -1, -1, -1, -1);
    n_checks++; if (n_st != 3) begin n_fail++; $display("FAIL rmid_count got %0d exp 3", n_st); end
    n_checks++; if (lnn_a !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_strobe got %b exp 1", lnn_a); end
    for (int i = 0; i < 3; i++) saved[i] = st_note[i];
    reset = 1'b0;
    #1;
    n_checks++; if (lnn_a !== 1'b0) begin n_fail++; $display("FAIL rmid_strobe got %b exp 0", lnn_a); end
    n_checks++; if (note_a !== 6'd0) begin n_fail++; $display("FAIL rmid_note got %0d exp 0", note_a); end
    n_checks++; if (idx_a !== 5'd0) begin n_fail++; $display("FAIL rmid_index got %0d exp 0", idx_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", busy_a); end
    n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL rmid_done got %b exp 0", done_a); end
    strobes = 0;
    repeat (4) begin @(posedge clk); #1; if (lnn_a !== 1'b0) strobes++; end
    n_checks++; if (strobes != 0) begin n_fail++; $display("FAIL rmid_no_strobe got %0d exp 0", strobes); end
    reset = 1'b1;
    capture(1, 0, 0, -1, -1, -1, -1, -1, -1);
    build_model(0, 0);
    n_checks++; if (n_st != 8) begin n_fail++; $display("FAIL rmid_rerun_count got %0d exp 8", n_st); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (st_note[i] !== saved[i]) begin n_fail++; $display("FAIL rmid_repeat%0d got %0d exp %0d", i, st_note[i], saved[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (st_note[i] !== exp_note[i]) begin n_fail++; $display("FAIL rmid_note%0d got %0d exp %0d", i, st_note[i], exp_note[i]); end
    end
  endtask

  task automatic test_seed_zero();
    sel = 0;
    capture(1, 0, 8'hA5, -1, -1, -1, -1, -1, -1);
    build_model(0, 8'hA5);
    n_checks++; if (n_st != 16) begin n_fail++; $display("FAIL seed0_count got %0d exp 16", n_st); end
    n_checks++; if (st_t[0] != 9) begin n_fail++; $display("FAIL seed0_t0 got %0d exp 9", st_t[0]); end
    n_checks++; if (st_note[0] !== 6'd24) begin n_fail++; $display("FAIL seed0_n0 got %0d exp 24", st_note[0]); end
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (st_note[i] !== exp_note[i]) begin n_fail++; $display("FAIL seed0_note%0d got %0d exp %0d", i, st_note[i], exp_note[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_angry();
    test_sad_enable();
    test_busy_trigger();
    test_reset_mid();
    test_seed_zero();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
